// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Fetch-side branch prediction (direct-mapped BTB + 2-bit BHT) and
//   execute-side branch/JALR resolution with redirect on mispredict.
//
//   Optional build macro: BRANCH_STATS_EN adds resolve/mispredict counters.
//
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     F_PC                fetch PC for lookup
//     Pred_Taken/Target   fetch prediction (combinational)
//     Ex_*                EX-stage instruction info and carried prediction
//     PC_Imm, PC_Four     Ex_PC+Ex_Imm, Ex_PC+4 (32-bit, wrapping)
//     BrPC, PcSel         redirect target and redirect/flush request
//     Stat_Branches       (BRANCH_STATS_EN) resolve-event count
//     Stat_Mispredicts    (BRANCH_STATS_EN) mispredict count
module branch_predict_unit #(
    parameter int unsigned PC_W        = 9,
    parameter int unsigned BHT_ENTRIES = 16,
    parameter logic [1:0]  CTR_INIT    = 2'b01
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   F_PC,
    output logic              Pred_Taken,
    output logic [31:0]       Pred_Target,
    input  logic              Ex_Valid,
    input  logic [PC_W-1:0]   Ex_PC,
    input  logic              Ex_Branch,
    input  logic              Ex_Jalr,
    input  logic [31:0]       Ex_Imm,
    input  logic [31:0]       Ex_AluResult,
    input  logic              Ex_PredTaken,
    input  logic [31:0]       Ex_PredTarget,
    output logic [31:0]       PC_Imm,
    output logic [31:0]       PC_Four,
    output logic [31:0]       BrPC,
    output logic              PcSel
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       Stat_Branches,
    output logic [31:0]       Stat_Mispredicts
`endif
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
    // PC_W must leave at least one tag bit above the index and byte offset.
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : 2'(c + 2'd1);
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : 2'(c - 2'd1);
    endfunction

    // Table storage
    logic             valid_q  [BHT_ENTRIES];
    logic [TAG_W-1:0] tag_q    [BHT_ENTRIES];
    logic [31:0]      target_q [BHT_ENTRIES];
    logic [1:0]       ctr_q    [BHT_ENTRIES];

    // Byte-offset bits never participate in indexing or tagging
    logic unused_pc_bits;
    assign unused_pc_bits = ^{F_PC[1:0], Ex_PC[1:0]};

    // Fetch lookup
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    always_comb begin
        f_idx       = F_PC[IDX_W+1:2];
        f_tag       = F_PC[PC_W-1:IDX_W+2];
        f_hit       = !reset && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        Pred_Taken  = f_hit && ctr_q[f_idx][1];
        Pred_Target = f_hit ? target_q[f_idx] : 32'd0;
    end

    // Execute resolve
    logic [31:0]      ex_pc_ext;
    logic             ctl_act;
    logic             taken;
    logic [31:0]      act_tgt;
    logic             mispredict;

    assign ex_pc_ext = 32'(Ex_PC);
    assign PC_Imm    = ex_pc_ext + Ex_Imm;
    assign PC_Four   = ex_pc_ext + 32'd4;

    always_comb begin
        ctl_act    = Ex_Valid && (Ex_Branch || Ex_Jalr);
        taken      = Ex_Jalr || (Ex_Branch && Ex_AluResult[0]);
        act_tgt    = Ex_Jalr ? {Ex_AluResult[31:1], 1'b0} : PC_Imm;
        mispredict = ctl_act &&
                     ((taken != Ex_PredTaken) || (taken && (act_tgt != Ex_PredTarget)));
        PcSel      = !reset && mispredict;
        BrPC       = 32'd0;
        if (PcSel) begin
            BrPC = taken ? act_tgt : PC_Four;
        end
    end

    // Table update decision
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             u_alloc;   // write valid/tag/target
    logic             u_ctr_en;  // write counter
    logic [1:0]       u_ctr_d;

    always_comb begin
        u_idx    = Ex_PC[IDX_W+1:2];
        u_tag    = Ex_PC[PC_W-1:IDX_W+2];
        u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_alloc  = 1'b0;
        u_ctr_en = 1'b0;
        u_ctr_d  = ctr_q[u_idx];
        if (ctl_act) begin
            if (Ex_Jalr) begin
                u_alloc  = 1'b1;
                u_ctr_en = 1'b1;
                u_ctr_d  = 2'b11;
            end else if (taken) begin
                u_alloc  = 1'b1;
                u_ctr_en = 1'b1;
                // A replaced entry starts one step above the reset value
                u_ctr_d  = u_hit ? sat_inc(ctr_q[u_idx]) : sat_inc(CTR_INIT);
            end else if (u_hit) begin
                u_ctr_en = 1'b1;
                u_ctr_d  = sat_dec(ctr_q[u_idx]);
            end
        end
    end

    // Table state register; an update coincident with reset is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= CTR_INIT;
            end
        end else begin
            if (u_alloc) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= act_tgt;
            end
            if (u_ctr_en) begin
                ctr_q[u_idx] <= u_ctr_d;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Event counters, wrap at 2^32
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (ctl_act)    stat_br_d = stat_br_q + 32'd1;
        if (mispredict) stat_mp_d = stat_mp_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_br_q <= 32'd0;
            stat_mp_q <= 32'd0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign Stat_Branches    = stat_br_q;
    assign Stat_Mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed scenarios then random
// traffic, checked against a behavioural table model.
module tb_branch_predict_unit;

    localparam int unsigned PC_W    = 9;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CINIT   = 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [PC_W-1:0]  F_PC;
    logic             Pred_Taken;
    logic [31:0]      Pred_Target;
    logic             Ex_Valid;
    logic [PC_W-1:0]  Ex_PC;
    logic             Ex_Branch;
    logic             Ex_Jalr;
    logic [31:0]      Ex_Imm;
    logic [31:0]      Ex_AluResult;
    logic             Ex_PredTaken;
    logic [31:0]      Ex_PredTarget;
    logic [31:0]      PC_Imm;
    logic [31:0]      PC_Four;
    logic [31:0]      BrPC;
    logic             PcSel;
`ifdef BRANCH_STATS_EN
    logic [31:0]      Stat_Branches;
    logic [31:0]      Stat_Mispredicts;
`endif

    always #5 clk = ~clk;

    branch_predict_unit #(.PC_W(PC_W), .BHT_ENTRIES(ENTRIES), .CTR_INIT(2'b01)) dut (
        .clk(clk), .reset(reset), .F_PC(F_PC),
        .Pred_Taken(Pred_Taken), .Pred_Target(Pred_Target),
        .Ex_Valid(Ex_Valid), .Ex_PC(Ex_PC), .Ex_Branch(Ex_Branch), .Ex_Jalr(Ex_Jalr),
        .Ex_Imm(Ex_Imm), .Ex_AluResult(Ex_AluResult),
        .Ex_PredTaken(Ex_PredTaken), .Ex_PredTarget(Ex_PredTarget),
        .PC_Imm(PC_Imm), .PC_Four(PC_Four), .BrPC(BrPC), .PcSel(PcSel)
`ifdef BRANCH_STATS_EN
        , .Stat_Branches(Stat_Branches), .Stat_Mispredicts(Stat_Mispredicts)
`endif
    );

    typedef struct packed {
        logic        rst;
        logic        pt;
        logic [31:0] ptg;
        logic        ps;
        logic [31:0] br;
        logic [31:0] pimm;
        logic [31:0] pfour;
        logic [31:0] nbr;
        logic [31:0] nmp;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   drv_done = 0;

    // Reference model: one record per table slot, plus event counts
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_nbr, m_nmp;

    function automatic int unsigned slot_of(input logic [PC_W-1:0] pc);
        return (int'(pc) / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [PC_W-1:0] pc);
        return int'(pc) / (4 * ENTRIES);
    endfunction

    function automatic bit model_hit(input logic [PC_W-1:0] pc);
        return m_valid[slot_of(pc)] && (m_tag[slot_of(pc)] == tag_of(pc));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = CINIT;
        end
        m_nbr = 0; m_nmp = 0;
    endtask

    // Apply one cycle: drive, predict outputs, advance model to post-edge state
    task automatic step(input bit rst, input logic [PC_W-1:0] fpc, input bit v,
                        input bit br, input bit jr, input logic [PC_W-1:0] epc,
                        input logic [31:0] imm, input logic [31:0] alu,
                        input bit ptk, input logic [31:0] ptg);
        exp_t e;
        bit act, tk, mis;
        logic [31:0] at, pc32;
        int unsigned s;
        reset = rst; F_PC = fpc; Ex_Valid = v; Ex_Branch = br; Ex_Jalr = jr;
        Ex_PC = epc; Ex_Imm = imm; Ex_AluResult = alu;
        Ex_PredTaken = ptk; Ex_PredTarget = ptg;

        pc32    = {{(32-PC_W){1'b0}}, epc};
        e.rst   = rst;
        e.pimm  = pc32 + imm;
        e.pfour = pc32 + 32'd4;
        e.pt    = !rst && model_hit(fpc) && (m_ctr[slot_of(fpc)] >= 2);
        e.ptg   = model_hit(fpc) ? m_tgt[slot_of(fpc)] : 32'd0;
        act     = v && (br || jr);
        tk      = jr || (br && alu[0]);
        at      = jr ? (alu & 32'hFFFF_FFFE) : e.pimm;
        mis     = act && ((tk != ptk) || (tk && at != ptg));
        e.ps    = mis && !rst;
        e.br    = !e.ps ? 32'd0 : (tk ? at : e.pfour);
        e.nbr   = m_nbr;
        e.nmp   = m_nmp;
        exp_q.push_back(e);

        if (rst) begin
            model_clear();
        end else if (act) begin
            s = slot_of(epc);
            m_nbr = m_nbr + 1;
            if (mis) m_nmp = m_nmp + 1;
            if (jr) begin
                m_ctr[s] = 3;
            end else if (tk) begin
                m_ctr[s] = model_hit(epc) ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3)
                                          : ((CINIT < 3) ? CINIT + 1 : 3);
            end else if (model_hit(epc)) begin
                m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
            end
            if (tk) begin
                m_valid[s] = 1; m_tag[s] = tag_of(epc); m_tgt[s] = at;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [PC_W-1:0] fpc);
        step(0, fpc, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are combinational, sampled mid-low-phase each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc_imm",  PC_Imm,  e.pimm);
                check("pc_four", PC_Four, e.pfour);
                check("pred_taken", 32'(Pred_Taken), 32'(e.pt));
                if (!e.rst) check("pred_target", Pred_Target, e.ptg);
                check("pcsel", 32'(PcSel), 32'(e.ps));
                check("brpc",  BrPC, e.br);
`ifdef BRANCH_STATS_EN
                if (!e.rst) begin
                    check("stat_branches",    Stat_Branches,    e.nbr);
                    check("stat_mispredicts", Stat_Mispredicts, e.nmp);
                end
`endif
            end
        end
    end

    // Stimulus
    initial begin
        logic [PC_W-1:0] fpc, epc;
        logic [31:0] imm, alu, ptg;
        bit v, br, jr, ptk;
        model_clear();
        reset = 1; F_PC = 0; Ex_Valid = 0; Ex_PC = 0; Ex_Branch = 0; Ex_Jalr = 0;
        Ex_Imm = 0; Ex_AluResult = 0; Ex_PredTaken = 0; Ex_PredTarget = 0;
        @(negedge clk);
        step(1, 9'h040, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 9'h040, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(9'h040);

        // Taken branch, predicted not-taken; then lookup hits
        step(0, 9'h040, 1, 1, 0, 9'h040, 32'h20, 32'h1, 0, 0);
        idle(9'h040);
        // Not-taken, predicted taken; then saturate down
        step(0, 9'h040, 1, 1, 0, 9'h040, 32'h20, 32'h0, 1, 32'h60);
        idle(9'h040);
        for (int i = 0; i < 4; i++) step(0, 9'h040, 1, 1, 0, 9'h040, 32'h20, 32'h0, 0, 0);
        idle(9'h040);

        // JALR
        step(0, 9'h080, 1, 0, 1, 9'h080, 32'h0, 32'h123, 0, 0);
        step(0, 9'h080, 1, 0, 1, 9'h080, 32'h0, 32'h123, 1, 32'h122);
        idle(9'h080);

        // Aliasing replacement
        step(0, 9'h040, 1, 1, 0, 9'h040, 32'h20, 32'h1, 0, 0);
        step(0, 9'h040, 1, 1, 0, 9'h040, 32'h20, 32'h1, 1, 32'h60);
        step(0, 9'h140, 1, 1, 0, 9'h140, 32'h10, 32'h1, 0, 0);
        idle(9'h040);
        idle(9'h140);

        // Reset coincident with a taken resolve
        step(1, 9'h140, 1, 1, 0, 9'h0C0, 32'h40, 32'h1, 0, 0);
        idle(9'h0C0);
        idle(9'h140);
        idle(9'h080);

        // Wrap-around of the 32-bit adder
        step(0, 9'h000, 1, 1, 0, 9'h1FC, 32'hFFFF_FE10, 32'h1, 0, 0);
        idle(9'h1FC);

        // Randomized traffic over a small PC pool to exercise hits and aliasing
        for (int n = 0; n < 600; n++) begin
            fpc = 9'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2));
            epc = 9'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2));
            if ($urandom_range(0, 7) == 0) epc = 9'($urandom);
            v   = ($urandom_range(0, 5) != 0);
            jr  = ($urandom_range(0, 3) == 0);
            br  = !jr ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 7) == 0);
            imm = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 255) * 4) : $urandom;
            alu = $urandom;
            if ($urandom_range(0, 1) != 0) begin
                ptk = model_hit(epc) && (m_ctr[slot_of(epc)] >= 2);
                ptg = model_hit(epc) ? m_tgt[slot_of(epc)] : 32'd0;
            end else begin
                ptk = $urandom_range(0, 1) != 0;
                ptg = $urandom;
            end
            step(($urandom_range(0, 63) == 0), fpc, v, br, jr, epc, imm, alu, ptk, ptg);
        end
        drv_done = 1;
    end

    // Drain and summary, bounded
    initial begin
        int budget;
        budget = 5000;
        while (!(drv_done && exp_q.size() == 0) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            failures++;
            $display("FAIL timeout actual=%0d pending required=0", exp_q.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the pipeline's combinational branch resolver.
- Fetch side: a direct-mapped BTB plus a 2-bit BHT predict the next PC.
- Execute side: resolves conditional branches and JALR against the prediction, raises a redirect/flush on mispredict, and trains the tables.
- Sits between the IF stage (PC mux) and the EX stage (ALU compare result).

Parameters:
- PC_W, 9, PC width in bits; PC is zero-extended to 32 bits internally.
- BHT_ENTRIES, 16, number of BTB/BHT entries; power of 2, minimum 2.
- IDX_W, $clog2(BHT_ENTRIES), index width (derived, not overridden).
- CTR_INIT, 2'b01, counter value after reset (weakly not-taken).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- F_PC  in  PC_W  fetch PC
- Pred_Taken  out  1  fetch prediction: redirect to Pred_Target
- Pred_Target  out  32  predicted target
- Ex_Valid  in  1  EX stage holds a valid instruction
- Ex_PC  in  PC_W  PC of the EX instruction
- Ex_Branch  in  1  conditional branch
- Ex_Jalr  in  1  JAL/JALR (unconditional, target from ALU)
- Ex_Imm  in  32  branch immediate
- Ex_AluResult  in  32  bit0 = compare outcome (branch); full jump target (jalr)
- Ex_PredTaken  in  1  prediction carried down the pipe for this instruction
- Ex_PredTarget  in  32  predicted target carried down the pipe
- PC_Imm  out  32  {0,Ex_PC}+Ex_Imm
- PC_Four  out  32  {0,Ex_PC}+4
- BrPC  out  32  redirect target
- PcSel  out  1  redirect/flush request (mispredict)

Behaviour:
- Index = PC[IDX_W+1:2]; tag = PC[PC_W-1:IDX_W+2] (TAG_W ≥ 1 required).
- Per entry: valid, tag, target[31:0], ctr[1:0].
- Lookup (combinational on F_PC):
  - hit = valid && tag match.
  - Pred_Taken = hit && ctr[1]; Pred_Target = hit ? target : 0.
- Resolve (combinational; active only when Ex_Valid && (Ex_Branch || Ex_Jalr)):
  - taken = Ex_Jalr || (Ex_Branch && Ex_AluResult[0]).
  - act_tgt = Ex_Jalr ? {Ex_AluResult[31:1],1'b0} : PC_Imm.
  - mispredict = (taken != Ex_PredTaken) || (taken && act_tgt != Ex_PredTarget).
  - PcSel = mispredict.
  - BrPC = taken ? act_tgt : PC_Four; BrPC = 0 when PcSel = 0.
  - All 32-bit adds wrap modulo 2^32.
- Update (posedge clk, same resolve condition):
  - Branch taken: ctr saturating +1 (max 11). Branch not taken: saturating −1 (min 00).
  - Jalr: ctr set to 11.
  - Taken: write valid=1, tag, target=act_tgt.
  - Not taken with tag miss: ctr untouched, entry not allocated.
  - Not taken with tag hit: ctr decrements, target kept.
  - Taken with tag miss: entry replaced; ctr loaded as CTR_INIT+1 (branch) or 11 (jalr).
- Ex_Valid=0 or a non-control instruction: PcSel=0, BrPC=0, no table write.
- Same-cycle lookup and update to the same index: lookup returns the pre-update value (no bypass).
- Reset: all valid=0, ctr=CTR_INIT, target=0, tag=0 on the first clock with reset high.
  - Lookups during reset return Pred_Taken=0.
  - An update coincident with reset is discarded.
- Outputs while reset is high:
  - Pred_Taken=0, PcSel=0, BrPC=0.
  - PC_Imm/PC_Four stay combinational from their inputs.

Optional Feature:
- BRANCH_STATS_EN defined: adds outputs Stat_Branches[31:0] and Stat_Mispredicts[31:0].
  - Both increment on each resolve event and each mispredict respectively.
  - Both wrap at 2^32 and clear on reset.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- After reset, F_PC=0x040 -> Pred_Taken=0, Pred_Target=0; Ex_Valid=0 -> PcSel=0, BrPC=0.
- Branch at Ex_PC=0x040, Imm=0x20, AluResult=1, Ex_PredTaken=0 -> PcSel=1, BrPC=0x060. Next cycle, F_PC=0x040 -> hit, ctr=10, Pred_Taken=1, Pred_Target=0x060.
- Same branch, AluResult=0, Ex_PredTaken=1, PredTarget=0x060 -> PcSel=1, BrPC=0x044; ctr 10->01, Pred_Taken=0. Four consecutive not-taken resolves saturate ctr at 00.
- Jalr at Ex_PC=0x080, AluResult=0x0000_0123, Ex_PredTaken=0 -> PcSel=1, BrPC=0x122; entry ctr=11. Re-resolving with Ex_PredTaken=1, PredTarget=0x122 -> PcSel=0.
- Aliasing: train 0x040 taken, then resolve taken at 0x140 (same index, different tag) -> entry replaced; F_PC=0x040 misses (Pred_Taken=0).
- Reset asserted in the same cycle as a taken resolve -> no table write; all lookups miss afterwards. With BRANCH_STATS_EN, both counters read 0.
